// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings, default latencies and payload types for the HI/LO multiply/divide unit.
package muldiv_ctrl_pkg;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  typedef struct packed {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
  } md_result_t;

  function automatic logic is_start_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_alu.sv
// Combinational 32x32 multiply/divide datapath producing the full {HI,LO} result,
// including the MIPS divide-by-zero and signed-overflow results.
module muldiv_alu
  import muldiv_ctrl_pkg::*;
(
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] res_hi,
  output logic [XLEN-1:0] res_lo
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic signed [2*XLEN-1:0] w_prod_s;
  logic        [2*XLEN-1:0] w_prod_u;
  logic                     w_div_zero;
  logic                     w_div_ovf;

  assign w_prod_s   = $signed({{XLEN{a[XLEN-1]}}, a}) * $signed({{XLEN{b[XLEN-1]}}, b});
  assign w_prod_u   = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
  assign w_div_zero = (b == '0);
  assign w_div_ovf  = (a == INT_MIN) && (b == '1);

  // Divides are only evaluated on the guarded path so 0 and INT_MIN/-1 never reach the operators.
  always_comb begin
    res_hi = '0;
    res_lo = '0;
    case (op)
      MD_MULT:  {res_hi, res_lo} = w_prod_s;
      MD_MULTU: {res_hi, res_lo} = w_prod_u;
      MD_DIV: begin
        if (w_div_zero) begin
          res_hi = a;
          res_lo = '1;
        end else if (w_div_ovf) begin
          res_hi = '0;
          res_lo = INT_MIN;
        end else begin
          res_lo = XLEN'($signed(a) / $signed(b));
          res_hi = XLEN'($signed(a) % $signed(b));
        end
      end
      MD_DIVU: begin
        if (w_div_zero) begin
          res_hi = a;
          res_lo = '1;
        end else begin
          res_lo = a / b;
          res_hi = a % b;
        end
      end
      default: begin
        res_hi = '0;
        res_lo = '0;
      end
    endcase
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// E-stage multiply/divide controller: fixed-latency busy window, pending result
// buffer and architectural HI/LO registers with the MFHI/MFLO read mux.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      op,
  input  logic            op_valid,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  md_result_t       r_pend, w_pend_nxt;
  logic [XLEN-1:0]  r_hi, r_lo, w_hi_nxt, w_lo_nxt;
  logic [XLEN-1:0]  w_alu_hi, w_alu_lo;
  logic             w_start;

  muldiv_alu u_alu (
    .op     (op),
    .a      (a),
    .b      (b),
    .res_hi (w_alu_hi),
    .res_lo (w_alu_lo)
  );

  assign w_start = op_valid && is_start_op(op) && (r_state == ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_pend  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pend  <= w_pend_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
    end
  end

  // Writes and starts are only honoured in IDLE; RUN just counts down to the commit.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pend_nxt  = r_pend;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nxt   = ST_RUN;
          w_cnt_nxt     = is_div_op(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          w_pend_nxt.hi = w_alu_hi;
          w_pend_nxt.lo = w_alu_lo;
        end else if (op_valid && (op == MD_MTHI)) begin
          w_hi_nxt = a;
        end else if (op_valid && (op == MD_MTLO)) begin
          w_lo_nxt = a;
        end
      end
      ST_RUN: begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_hi_nxt    = r_pend.hi;
          w_lo_nxt    = r_pend.lo;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    rdata = '0;
    if (op == MD_MFHI) begin
      rdata = r_hi;
    end else if (op == MD_MFLO) begin
      rdata = r_lo;
    end
  end

  assign busy = w_start || (r_state == ST_RUN);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
